// File: rtl/block_petrify.sv
`default_nettype none
// ============================================================================
// Module   : block_petrify
// Purpose  : Clocked single-slot pipeline stage for a 4-phase (return-to-zero)
//            req/ack bundled-data handshake. Captures data_in on an upstream
//            request, acknowledges upstream, then presents the held word
//            downstream and waits for its acknowledge. All outputs are
//            decoded from registered state, so there is no in->out
//            combinational path.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous reset, active-high
//            req_in   - upstream request (data_in valid while high)
//            ack_in   - acknowledge to upstream
//            data_in  - upstream data word [WIDTH-1:0]
//            req_out  - request to downstream (data_out valid while high)
//            ack_out  - acknowledge from downstream
//            data_out - held data word [WIDTH-1:0]
// Config   : BLOCK_PETRIFY_SYNC_EN - when defined, req_in and ack_out pass
//            through 2-flop synchronizers before the FSM (+2 clk latency).
// Revision : 1.0 - initial release
// ============================================================================
module block_petrify #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  output logic             ack_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY     = 2'b01,
    OUT_PEND = 2'b10,
    IN_PEND  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_s;   // request as seen by the FSM
  logic             ack_s;   // downstream ack as seen by the FSM

`ifdef BLOCK_PETRIFY_SYNC_EN
  logic req_s1_q, req_s1_d, req_s2_q, req_s2_d;
  logic ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;

  always_comb begin
    req_s1_d = req_in;
    req_s2_d = req_s1_q;
    ack_s1_d = ack_out;
    ack_s2_d = ack_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      req_s1_q <= req_s1_d;
      req_s2_q <= req_s2_d;
      ack_s1_q <= ack_s1_d;
      ack_s2_q <= ack_s2_d;
    end
  end

  assign req_s = req_s2_q;
  assign ack_s = ack_s2_q;
`else
  assign req_s = req_in;
  assign ack_s = ack_out;
`endif

  // Next-state and capture logic. data_in is taken straight from the port at
  // the capture edge: the bundled-data rule keeps it stable while req_in is
  // high, which covers the synchronizer delay too.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // Capture is blocked while the downstream ack is still high, so a new
        // word is never offered before the previous ack has returned to zero.
        if (req_s && !ack_s) begin
          data_d  = data_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req_s && ack_s)   state_d = IDLE;
        else if (!req_s)       state_d = OUT_PEND;
        else if (ack_s)        state_d = IN_PEND;
        else                   state_d = BUSY;
      end
      OUT_PEND: begin
        // Slot still full: a fresh upstream request is held off here.
        if (ack_s) state_d = IDLE;
      end
      IN_PEND: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Outputs are pure decodes of the registered state.
  assign ack_in   = (state_q == BUSY) || (state_q == IN_PEND);
  assign req_out  = (state_q == BUSY) || (state_q == OUT_PEND);
  assign data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_block_petrify.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_petrify
// Purpose  : Self-checking bench for block_petrify. Directed vector table for
//            the default build plus hand-written multi-cycle sequences; a
//            latency sequence replaces the table when BLOCK_PETRIFY_SYNC_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_petrify;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst;
  logic             req_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_in;
  logic             req_out;
  logic             ack_out;
  logic [WIDTH-1:0] data_out;

  int checks;
  int errors;

  block_petrify #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] din;
    logic             e_ack_in;
    logic             e_req_out;
    logic [WIDTH-1:0] e_dout;
  } vec_t;

  // Compare all three outputs against expectations; one FAIL line per miss.
  task automatic check(input string name, input logic e_ai, input logic e_ro,
                       input logic [WIDTH-1:0] e_d);
    checks++;
    if (ack_in !== e_ai || req_out !== e_ro || data_out !== e_d) begin
      errors++;
      $display("FAIL %s: got ack_in=%b req_out=%b data_out=%0d, expected ack_in=%b req_out=%b data_out=%0d",
               name, ack_in, req_out, data_out, e_ai, e_ro, e_d);
    end
  endtask

  task automatic drive(input logic r, input logic rq, input logic ak,
                       input logic [WIDTH-1:0] d);
    rst = r; req_in = rq; ack_out = ak; data_in = d;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    #1;

`ifndef BLOCK_PETRIFY_SYNC_EN
    begin
      vec_t vecs[$];
      // rst req ack din | ack_in req_out dout
      vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0}); // reset
      vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0}); // reset wins
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0}); // idle
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2}); // capture 2
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2}); // OUT_PEND
      vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2}); // IDLE
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5}); // capture 5
      vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5}); // IN_PEND
      vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd5}); // IDLE, ack high
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3}); // capture 3
      vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd3}); // simultaneous
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 3'd4}); // capture 4
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4}); // OUT_PEND
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 3'd4}); // held off
      vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 3'd4}); // IDLE
      vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 3'd4}); // blocked by ack
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 3'd7}); // capture 7
      vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 3'd7}); // BUSY hold
      vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0}); // reset mid-xfer
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0});

      for (int i = 0; i < vecs.size(); i++) begin
        drive(vecs[i].rst, vecs[i].req, vecs[i].ack, vecs[i].din);
        step();
        check($sformatf("vec%0d", i), vecs[i].e_ack_in, vecs[i].e_req_out,
              vecs[i].e_dout);
      end
    end

    // Upstream holds req_in high after downstream ack: IN_PEND must persist
    // without a second capture, whatever data_in does meanwhile.
    drive(1'b0, 1'b1, 1'b0, 3'd6); step(); check("hold_cap", 1'b1, 1'b1, 3'd6);
    drive(1'b0, 1'b1, 1'b1, 3'd6); step(); check("hold_inp", 1'b1, 1'b0, 3'd6);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(k));
      step();
      check($sformatf("hold_stay%0d", k), 1'b1, 1'b0, 3'd6);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0); step(); check("hold_idle", 1'b0, 1'b0, 3'd6);
    drive(1'b0, 1'b0, 1'b0, 3'd0); step(); check("hold_nodup", 1'b0, 1'b0, 3'd6);

    // Reset while in OUT_PEND drops req_out on the reset edge.
    drive(1'b0, 1'b1, 1'b0, 3'd5); step(); check("rst2_cap", 1'b1, 1'b1, 3'd5);
    drive(1'b0, 1'b0, 1'b0, 3'd5); step(); check("rst2_outp", 1'b0, 1'b1, 3'd5);
    drive(1'b1, 1'b0, 1'b0, 3'd0); step(); check("rst2_rst", 1'b0, 1'b0, 3'd0);
`else
    // Synchronized build: every handshake latency is 3 clk instead of 1.
    step(); step(); check("s_reset", 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 1'b0, 3'd2);
    step(); check("s_req1", 1'b0, 1'b0, 3'd0);
    step(); check("s_req2", 1'b0, 1'b0, 3'd0);
    step(); check("s_req3", 1'b1, 1'b1, 3'd2);
    drive(1'b0, 1'b0, 1'b0, 3'd2);
    step(); check("s_fall1", 1'b1, 1'b1, 3'd2);
    step(); check("s_fall2", 1'b1, 1'b1, 3'd2);
    step(); check("s_fall3", 1'b0, 1'b1, 3'd2);
    drive(1'b0, 1'b0, 1'b1, 3'd0);
    step(); check("s_ack1", 1'b0, 1'b1, 3'd2);
    step(); check("s_ack2", 1'b0, 1'b1, 3'd2);
    step(); check("s_ack3", 1'b0, 1'b0, 3'd2);
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("s_idle%0d", k), 1'b0, 1'b0, 3'd2);
    end
    drive(1'b0, 1'b1, 1'b0, 3'd5);
    step(); step(); step(); check("s_cap5", 1'b1, 1'b1, 3'd5);
    drive(1'b1, 1'b1, 1'b0, 3'd5);
    step(); check("s_rst", 1'b0, 1'b0, 3'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
